imem_loader: RTL and testbench

Boot-time writer for the Harvard instruction memory: accepts a framed byte stream (length header, little-endian instruction words, XOR checksum), packs bytes into 32-bit words and writes them to consecutive word addresses from 0. It holds the pipelined core in reset for the whole load and releases it only after a frame with a valid checksum. It sits beside the processor top, driving the instruction memory's write port and the core's reset.

---
 rtl/imem_loader_pkg.sv | 7 +
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and frame geometry shared by the instruction-memory loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_e;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: packs a little-endian byte stream into 32-bit words.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          valid_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          word_done_o
);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic [8*BYTES_PER_WORD-9:0]   acc_q, acc_d;
    // The final byte bypasses the accumulator so the word is complete in the same cycle.
    assign word_o      = {byte_i, acc_q};
    assign word_done_o = valid_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    always_comb begin
        lane_d = clear_i ? '0 : valid_i ? lane_q + 1'b1 : lane_q;
        acc_d  = clear_i ? '0 : valid_i ? {byte_i, acc_q[8*BYTES_PER_WORD-9:8]} : acc_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a framed, checksummed byte stream into instruction memory and gates core reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);
    state_e                 state_q;
    logic [8*HDR_BYTES-1:0] len_q;
    logic [LEN_W-1:0]       widx_q, widx_d, n_d;
    logic [7:0]             csum_q, csum_d;
    logic                   we_q, crst_q, done_q, err_q;
    logic [31:0]            addr_q, wd_q, word;
    logic                   take, can_start, word_done;
    assign byte_ready = state_q inside {LEN0, LEN1, DATA, CSUM};
    assign can_start  = start && (state_q inside {IDLE, DONE, ERR});
    assign take       = byte_valid && byte_ready;
    assign n_d        = {byte_data, len_q[7:0]};
    assign widx_d     = widx_q + 1'b1;
    assign csum_d     = csum_q ^ byte_data;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wd    = wd_q;
    assign core_rst   = crst_q;
    assign done       = done_q;
    assign error      = err_q;
    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (can_start),
        .valid_i    (take && state_q == DATA),
        .byte_i     (byte_data),
        .word_o     (word),
        .word_done_o(word_done)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR:
                    if (can_start) begin
                        state_q <= LEN0;
                        widx_q  <= '0;
                        csum_q  <= '0;
                        crst_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                LEN0:
                    if (take) begin
                        len_q[7:0] <= byte_data;
                        csum_q     <= csum_d;
                        state_q    <= LEN1;
                    end
                LEN1:
                    if (take) begin
                        len_q   <= n_d;
                        csum_q  <= csum_d;
                        state_q <= (n_d > MAX_N) ? ERR : (n_d == '0) ? CSUM : DATA;
                        err_q   <= n_d > MAX_N;
                    end
                DATA:
                    if (take) begin
                        csum_q <= csum_d;
                        if (word_done) begin
                            we_q    <= 1'b1;
                            wd_q    <= word;
                            addr_q  <= {14'b0, widx_q, 2'b00};
                            widx_q  <= widx_d;
                            state_q <= (widx_d == len_q) ? CSUM : DATA;
                        end
                    end
                CSUM:
                    if (take) begin
                        state_q <= (byte_data == csum_q) ? DONE : ERR;
                        done_q  <= byte_data == csum_q;
                        err_q   <= byte_data != csum_q;
                        crst_q  <= byte_data != csum_q;
                    end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level model plus directed sessions for the instruction-memory loader.
module tb_imem_loader;
    localparam int MAXW = 1024;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, core_rst, done, error;
    logic [31:0] imem_addr, imem_wd;
    int total = 0;
    int bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wdq[$];
    logic [7:0]  fr[$];

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: tracks position within the frame and derives what the loader must show.
    logic        m_sess, m_we, m_done, m_err, m_crst;
    logic [31:0] m_addr, m_wd, m_word;
    logic [7:0]  m_csum;
    int          m_pos, m_n;
    always @(posedge clk or posedge rst) begin
        int nn, k;
        logic [31:0] w;
        if (rst) begin
            m_sess <= 0; m_we <= 0; m_done <= 0; m_err <= 0; m_crst <= 1;
            m_addr <= 0; m_wd <= 0; m_word <= 0; m_csum <= 0; m_pos <= 0; m_n <= 0;
        end else begin
            m_we <= 0;
            if (start && !m_sess) begin
                m_sess <= 1; m_done <= 0; m_err <= 0; m_crst <= 1;
                m_pos <= 0; m_csum <= 0; m_word <= 0; m_n <= 0;
            end else if (byte_valid && m_sess) begin
                m_pos  <= m_pos + 1;
                m_csum <= m_csum ^ byte_data;
                if (m_pos == 0) m_n <= int'(byte_data);
                else if (m_pos == 1) begin
                    nn = int'(byte_data) * 256 + m_n;
                    m_n <= nn;
                    if (nn > MAXW) begin m_err <= 1; m_sess <= 0; end
                end else if (m_pos < 2 + 4 * m_n) begin
                    k = (m_pos - 2) % 4;
                    w = m_word | (32'(byte_data) << (8 * k));
                    if (k == 3) begin
                        m_we <= 1; m_wd <= w; m_word <= 0;
                        m_addr <= 32'(4 * ((m_pos - 2) / 4));
                    end else m_word <= w;
                end else begin
                    m_done <= byte_data == m_csum;
                    m_err  <= byte_data != m_csum;
                    m_crst <= byte_data != m_csum;
                    m_sess <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("byte_ready", 32'(byte_ready), 32'(m_sess));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wd", imem_wd, m_wd);
        chk("core_rst", 32'(core_rst), 32'(m_crst));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wdq.push_back(imem_wd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=ready");
        end
        tick();
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input int gap);
        foreach (fr[i]) send(fr[i], gap);
    endtask

    task automatic clr_log();
        wa.delete();
        wdq.delete();
    endtask

    initial begin
        logic [7:0] cs;
        logic [31:0] w;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // start together with a byte in IDLE: the byte must not be consumed
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        do_start();
        byte_valid = 1'b0;
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_no_writes", 32'(wa.size()), 32'd0);

        clr_log();
        do_start();
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        send_frame(0);
        chk("good_done", 32'(done), 32'd1);
        chk("good_core_rst", 32'(core_rst), 32'd0);
        chk("good_wr_cnt", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("good_addr0", wa[0], 32'h0);
            chk("good_data0", wdq[0], 32'h0000_0013);
            chk("good_addr1", wa[1], 32'h4);
            chk("good_data1", wdq[1], 32'h0010_0093);
        end

        clr_log();
        do_start();
        fr[10] = 8'h90;
        send_frame(0);
        chk("badcs_error", 32'(error), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_core_rst", 32'(core_rst), 32'd1);
        chk("badcs_wr_cnt", 32'(wa.size()), 32'd2);

        clr_log();
        do_start();
        send(8'h01, 0);
        send(8'h04, 0);
        chk("len_error", 32'(error), 32'd1);
        chk("len_ready", 32'(byte_ready), 32'd0);
        repeat (3) tick();
        chk("len_no_writes", 32'(wa.size()), 32'd0);

        do_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        chk("n0_done", 32'(done), 32'd1);
        chk("n0_core_rst", 32'(core_rst), 32'd0);
        chk("n0_no_writes", 32'(wa.size()), 32'd0);

        // gapped stream with an ignored start in the middle of the data
        clr_log();
        do_start();
        send(8'h01, 2);
        send(8'h00, 2);
        send(8'hEF, 2);
        do_start();
        send(8'hBE, 2);
        send(8'hAD, 2);
        send(8'hDE, 2);
        send(8'h23, 2);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_wr_cnt", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("gap_addr", wa[0], 32'h0);
            chk("gap_data", wdq[0], 32'hDEAD_BEEF);
        end
        clr_log();
        do_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_core_rst", 32'(core_rst), 32'd1);
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        send_frame(0);
        chk("restart_wr_cnt", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) chk("restart_addr0", wa[0], 32'h0);

        // largest legal program
        clr_log();
        fr = '{8'h00, 8'h04};
        for (int i = 0; i < MAXW; i++) begin
            w = {16'hC0DE, 16'(i)};
            for (int b = 0; b < 4; b++) fr.push_back(w[8*b +: 8]);
        end
        cs = 8'h00;
        foreach (fr[i]) cs ^= fr[i];
        fr.push_back(cs);
        do_start();
        send_frame(0);
        chk("max_done", 32'(done), 32'd1);
        chk("max_wr_cnt", 32'(wa.size()), 32'd1024);
        if (wa.size() == 1024) begin
            chk("max_last_addr", wa[1023], 32'h0000_0FFC);
            chk("max_last_data", wdq[1023], 32'hC0DE_03FF);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
